fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ptr_sync.sv | 24 ++
 rtl/fifo_rd_ctrl.sv | 69 ++++++
 tb/tb_fifo_rd_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and pointer encoding helpers.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH    = 8;
    localparam int unsigned FIFO_ADDRESS_WIDTH = 3;

    // Binary to reflected Gray code; callers cast the result to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer carrying a Gray pointer into the R_CLK domain.
module fifo_ptr_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             R_CLK,
    input  logic             R_RST,
    input  logic [WIDTH-1:0] D_PTR,
    output logic [WIDTH-1:0] Q_PTR
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; it feeds only the second stage.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            meta  <= '0;
            Q_PTR <= '0;
        end else begin
            meta  <= D_PTR;
            Q_PTR <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: read pointer, empty flag and a one-word
// registered output stage with valid/ready handshake.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH
) (
    input  logic                     R_CLK,
    input  logic                     R_RST,
    input  logic [ADDRESS_WIDTH:0]   WQ_PTR,
    input  logic [DATA_WIDTH-1:0]    RD_DATA,
    output logic [ADDRESS_WIDTH-1:0] RD_ADDR,
    output logic [ADDRESS_WIDTH:0]   RD_PTR,
    output logic                     R_INC,
    output logic                     EMPTY,
    output logic [DATA_WIDTH-1:0]    OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY
);

    localparam int unsigned PW = ADDRESS_WIDTH + 1;

    logic [PW-1:0] wq2_ptr;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic          pop;

    fifo_ptr_sync #(
        .WIDTH (PW)
    ) u_wq_sync (
        .R_CLK (R_CLK),
        .R_RST (R_RST),
        .D_PTR (WQ_PTR),
        .Q_PTR (wq2_ptr)
    );

    // Pop whenever a word is available and the output stage is free or being drained.
    always_comb begin
        pop        = !EMPTY && (!OUT_VALID || OUT_READY) && !R_RST;
        rbin_next  = rbin + PW'(pop);
        rgray_next = PW'(bin2gray(32'(rbin_next)));
    end

    assign R_INC   = pop;
    assign RD_ADDR = rbin[ADDRESS_WIDTH-1:0];

    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            rbin      <= '0;
            RD_PTR    <= '0;
            EMPTY     <= 1'b1;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            rbin   <= rbin_next;
            RD_PTR <= rgray_next;
            EMPTY  <= (rgray_next == wq2_ptr);
            if (pop) begin
                OUT_DATA  <= RD_DATA;
                OUT_VALID <= 1'b1;
            end else if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: the bench plays write side and memory, expected words
// are queued at write time and compared when the consumer accepts them.
module tb_fifo_rd_ctrl;

    logic       R_CLK = 1'b0;
    logic       R_RST = 1'b1;
    logic [3:0] WQ_PTR = 4'd0;
    logic [7:0] RD_DATA;
    logic [2:0] RD_ADDR;
    logic [3:0] RD_PTR;
    logic       R_INC;
    logic       EMPTY;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;

    logic [7:0] mem [8];
    logic [7:0] exp_q [$];
    int         pop_cycles [$];
    int         valid_cycles [$];

    int         vectors = 0;
    int         miscompares = 0;
    int         wr_cnt = 0;
    int         pops_total = 0;
    int         cyc = 0;
    bit         saw_wrap = 1'b0;
    bit         prev_hold = 1'b0;
    logic [2:0] prev_addr = 3'd0;
    logic [7:0] prev_data = 8'd0;

    always #5 R_CLK = ~R_CLK;

    assign RD_DATA = mem[RD_ADDR];

    fifo_rd_ctrl #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (3)
    ) dut (
        .R_CLK     (R_CLK),
        .R_RST     (R_RST),
        .WQ_PTR    (WQ_PTR),
        .RD_DATA   (RD_DATA),
        .RD_ADDR   (RD_ADDR),
        .RD_PTR    (RD_PTR),
        .R_INC     (R_INC),
        .EMPTY     (EMPTY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge();
        @(posedge R_CLK);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wr_cnt % 8] = d;
        exp_q.push_back(d);
        wr_cnt++;
        WQ_PTR = gray4(wr_cnt);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge R_CLK);
            done = (exp_q.size() == 0) && !OUT_VALID && (pops_total == wr_cnt);
        end
        check(done, "drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pointer tracking, pop legality, hold stability and scoreboard compare.
    always @(negedge R_CLK) begin
        logic [7:0] e;
        cyc++;
        if (R_RST) begin
            check(R_INC === 1'b0, "r_inc_in_reset", 32'(R_INC), 32'd0);
            pops_total = 0;
            prev_hold  = 1'b0;
        end else begin
            check(RD_PTR === gray4(pops_total), "rd_ptr", 32'(RD_PTR), 32'(gray4(pops_total)));
            check(RD_ADDR === 3'(pops_total), "rd_addr", 32'(RD_ADDR), 32'(3'(pops_total)));
            if (R_INC) begin
                check(!EMPTY, "pop_while_empty", 32'(EMPTY), 32'd0);
                check(pops_total < wr_cnt, "pop_beyond_writes", 32'(pops_total), 32'(wr_cnt));
                pop_cycles.push_back(cyc);
            end
            if (prev_hold) begin
                check(OUT_VALID === 1'b1, "hold_valid", 32'(OUT_VALID), 32'd1);
                check(OUT_DATA === prev_data, "hold_data", 32'(OUT_DATA), 32'(prev_data));
            end
            if (OUT_VALID) valid_cycles.push_back(cyc);
            if (OUT_VALID && OUT_READY) begin
                check(exp_q.size() != 0, "unexpected_word", 32'(OUT_DATA), 32'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check(OUT_DATA === e, "out_data", 32'(OUT_DATA), 32'(e));
                end
            end
            if (prev_addr == 3'd7 && RD_ADDR == 3'd0) saw_wrap = 1'b1;
            prev_addr = RD_ADDR;
            prev_hold = OUT_VALID && !OUT_READY;
            prev_data = OUT_DATA;
            if (R_INC) pops_total++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int p0;
        for (int i = 0; i < 8; i++) mem[i] = 8'd0;

        // Reset held for two edges.
        repeat (2) @(posedge R_CLK);
        @(negedge R_CLK);
        check(EMPTY === 1'b1, "reset_empty", 32'(EMPTY), 32'd1);
        check(OUT_VALID === 1'b0, "reset_valid", 32'(OUT_VALID), 32'd0);
        check(RD_PTR === 4'b0000, "reset_rd_ptr", 32'(RD_PTR), 32'd0);
        check(R_INC === 1'b0, "reset_r_inc", 32'(R_INC), 32'd0);

        // First word: two sync edges, one edge to clear EMPTY, then pop.
        drive_edge();
        R_RST = 1'b0;
        write_word(8'hA5);
        @(negedge R_CLK);
        @(negedge R_CLK);
        @(negedge R_CLK);
        check(EMPTY === 1'b1, "first_empty_still_set", 32'(EMPTY), 32'd1);
        check(R_INC === 1'b0, "first_no_early_pop", 32'(R_INC), 32'd0);
        @(negedge R_CLK);
        check(EMPTY === 1'b0, "first_empty_clear", 32'(EMPTY), 32'd0);
        check(R_INC === 1'b1, "first_pop", 32'(R_INC), 32'd1);
        @(negedge R_CLK);
        check(OUT_VALID === 1'b1, "first_valid", 32'(OUT_VALID), 32'd1);
        check(OUT_DATA === 8'hA5, "first_data", 32'(OUT_DATA), 32'hA5);
        check(RD_PTR === 4'b0001, "first_rd_ptr", 32'(RD_PTR), 32'd1);
        check(EMPTY === 1'b1, "first_empty_again", 32'(EMPTY), 32'd1);
        check(R_INC === 1'b0, "first_single_pop", 32'(R_INC), 32'd0);
        drain();

        // Backpressure: three words queued, consumer stalled.
        drive_edge();
        OUT_READY = 1'b0;
        p0 = pops_total;
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        repeat (12) drive_edge();
        @(negedge R_CLK);
        check(pops_total - p0 == 1, "bp_single_pop", 32'(pops_total - p0), 32'd1);
        check(R_INC === 1'b0, "bp_no_pop", 32'(R_INC), 32'd0);
        check(OUT_DATA === 8'h11, "bp_data_held", 32'(OUT_DATA), 32'h11);
        drain();

        // Streaming: eight words at once, consumer always ready; this also wraps to 12 pops.
        drive_edge();
        pop_cycles.delete();
        valid_cycles.delete();
        for (int i = 0; i < 8; i++) write_word(8'($urandom));
        repeat (20) @(negedge R_CLK);
        check(pop_cycles.size() == 8, "stream_pop_count", 32'(pop_cycles.size()), 32'd8);
        if (pop_cycles.size() == 8)
            check(pop_cycles[7] - pop_cycles[0] == 7, "stream_pop_back2back",
                  32'(pop_cycles[7] - pop_cycles[0]), 32'd7);
        check(valid_cycles.size() == 8, "stream_valid_count", 32'(valid_cycles.size()), 32'd8);
        if (valid_cycles.size() == 8)
            check(valid_cycles[7] - valid_cycles[0] == 7, "stream_valid_back2back",
                  32'(valid_cycles[7] - valid_cycles[0]), 32'd7);
        check(RD_PTR === 4'b1010, "wrap_rd_ptr", 32'(RD_PTR), 32'hA);
        check(saw_wrap, "wrap_addr_7_to_0", 32'(saw_wrap), 32'd1);
        check(EMPTY === 1'b1, "wrap_empty", 32'(EMPTY), 32'd1);
        drain();

        // Random traffic with random consumer stalls.
        repeat (400) begin
            drive_edge();
            OUT_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && (wr_cnt - pops_total) < 8) write_word(8'($urandom));
        end
        drain();

        // Reset mid-stream: one word in the output stage and four queued.
        drive_edge();
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge R_CLK);
            ok = OUT_VALID && (wr_cnt - pops_total == 4);
        end
        check(ok, "midrst_setup_timeout", 32'(wr_cnt - pops_total), 32'd4);
        drive_edge();
        R_RST  = 1'b1;
        WQ_PTR = 4'd0;
        wr_cnt = 0;
        exp_q.delete();
        @(negedge R_CLK);
        @(negedge R_CLK);
        check(OUT_VALID === 1'b0, "midrst_valid", 32'(OUT_VALID), 32'd0);
        check(RD_PTR === 4'b0000, "midrst_rd_ptr", 32'(RD_PTR), 32'd0);
        check(EMPTY === 1'b1, "midrst_empty", 32'(EMPTY), 32'd1);
        drive_edge();
        R_RST = 1'b0;

        repeat (150) begin
            drive_edge();
            OUT_READY = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 1) == 0 && (wr_cnt - pops_total) < 8) write_word(8'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
